// File: rtl/booth_seq_multiplier_if.sv
// Handshake and operand/result bundle between a requester and the Booth multiplier.
// The master side requests products; the slave side is the multiplier itself.
interface booth_seq_multiplier_if #(
  parameter int N = 8
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract step per cycle,
// N steps per product, feeding a 2N-bit adder with acc, +/-mcand and carry-in.
module booth_seq_multiplier #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_seq_multiplier_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mult_q, mult_d;
  logic            qPrev_q, qPrev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    product_q, product_d;

  logic [W-1:0]    addY;
  logic            addCin;
  logic [W-1:0]    addSum;

  // Adder operand select: subtraction is acc + ~mcand + 1, carry-out dropped.
  always_comb begin
    addY   = '0;
    addCin = 1'b0;
    case ({mult_q[0], qPrev_q})
      2'b01: addY = mcand_q;
      2'b10: begin
        addY   = ~mcand_q;
        addCin = 1'b1;
      end
      default: begin
        addY   = '0;
        addCin = 1'b0;
      end
    endcase
    addSum = acc_q + addY + {{(W-1){1'b0}}, addCin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      qPrev_q   <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      qPrev_q   <= qPrev_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    qPrev_d   = qPrev_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = {{N{bus.a[N-1]}}, bus.a};
          mult_d  = bus.b;
          qPrev_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        acc_d    = addSum;
        mcand_d  = {mcand_q[W-2:0], 1'b0};
        mult_d   = {1'b0, mult_q[N-1:1]};
        qPrev_d  = mult_q[0];
        cnt_d    = cnt_q + CW'(1);
        // The final step writes the fresh sum straight into the result register.
        if (cnt_q == CW'(N - 1)) begin
          product_d = addSum;
          state_d   = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.product = product_q;
endmodule
